// File: rtl/uart_baud_gen.sv
// uart_baud_gen: dual fractional baud-rate tick generator.
// Channel 0 produces the 1x bit-rate tick, channel 1 the 16x oversampling tick.
// Each channel counts intervals of (divisor + carry) clocks. The carry comes from
// a 4-bit accumulator of the fractional adjustment, so the average period is
// divisor + fra_adj/16 clocks.
// Build option: define UART_BAUDGEN_FRAC_EN to include the fractional
// accumulators. Without it, every interval is exactly divisor clocks and the
// fra_adj inputs are ignored.

module uart_baud_gen #(
  parameter int COUNTER_WIDTH = 20  // must be >= 17 to hold divisor + carry
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_divisor,
  input  logic [3:0]  i_fra_adj,
  input  logic [15:0] i_divisor_x16,
  input  logic [3:0]  i_fra_adj_x16,
  input  logic        i_baud_en,
  input  logic        i_baud_x16_en,
  output logic        o_baud,
  output logic        o_baud_x16
);

  // Index 0 is the 1x channel and index 1 is the 16x channel.
  logic [1:0][15:0] div_a;
  logic [1:0]       en_a;
  logic [1:0]       tick_a;

  assign div_a = {i_divisor_x16, i_divisor};
  assign en_a  = {i_baud_x16_en, i_baud_en};

`ifdef UART_BAUDGEN_FRAC_EN
  logic [1:0][3:0] fra_a;
  assign fra_a = {i_fra_adj_x16, i_fra_adj};
`else
  // The fractional inputs are intentionally left unconnected in this build.
  logic unused_fra;
  assign unused_fra = ^{i_fra_adj, i_fra_adj_x16};
`endif

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [COUNTER_WIDTH-1:0] cnt;
    logic [COUNTER_WIDTH-1:0] last;
    logic [16:0]              period;
    logic                     carry;
    logic                     active;
    logic                     wrap;
    logic                     tick;

    // A zero divisor idles the channel exactly like a cleared enable.
    assign active = en_a[ch] && (div_a[ch] != 16'd0);
    assign period = {1'b0, div_a[ch]} + {16'd0, carry};
    assign last   = COUNTER_WIDTH'(period) - COUNTER_WIDTH'(1);
    // Use >= rather than == so that a divisor lowered mid-count wraps
    // immediately instead of running past the new period.
    assign wrap   = (cnt >= last);

    // Period counter and registered single-cycle tick.
    // NOTE: sequential state uses non-blocking assignments, so every always_ff
    // samples the pre-edge values of cnt/carry regardless of evaluation order.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt  <= '0;
        tick <= 1'b0;
      end else if (!active) begin
        cnt  <= '0;
        tick <= 1'b0;
      end else if (wrap) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + COUNTER_WIDTH'(1);
        tick <= 1'b0;
      end
    end

`ifdef UART_BAUDGEN_FRAC_EN
    logic [3:0] acc;

    // Fraction accumulator: its overflow lengthens the next interval by one clock.
    // NOTE: the async reset clears the accumulator as well, so a reset always
    // restarts from a clean fractional phase.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        acc   <= 4'd0;
        carry <= 1'b0;
      end else if (!active) begin
        acc   <= 4'd0;
        carry <= 1'b0;
      end else if (wrap) begin
        {carry, acc} <= {1'b0, acc} + {1'b0, fra_a[ch]};
      end
    end
`else
    assign carry = 1'b0;
`endif

    assign tick_a[ch] = tick;
  end

  assign o_baud     = tick_a[0];
  assign o_baud_x16 = tick_a[1];

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: self-checking bench for uart_baud_gen.
// The reference model predicts tick edges from the schedule of interval
// lengths (divisor plus the carry implied by k*fra/16). It does not mirror the
// counter in the RTL. Honors UART_BAUDGEN_FRAC_EN in the same way as the RTL.

module tb_uart_baud_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] divisor, divisor_x16;
  logic [3:0]  fra_adj, fra_adj_x16;
  logic        baud_en, baud_x16_en;
  logic        o_baud, o_baud_x16;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int q1[$];
  int q16[$];

  // Model state per channel: edges since enable, edge of the next tick, and
  // the count of completed intervals.
  int m_e[2];
  int m_next[2];
  int m_k[2];

  uart_baud_gen #(.COUNTER_WIDTH(20)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_divisor     (divisor),
    .i_fra_adj     (fra_adj),
    .i_divisor_x16 (divisor_x16),
    .i_fra_adj_x16 (fra_adj_x16),
    .i_baud_en     (baud_en),
    .i_baud_x16_en (baud_x16_en),
    .o_baud        (o_baud),
    .o_baud_x16    (o_baud_x16)
  );

  // 40 ns system clock.
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Extra clock added to interval k: the integer part of k*fra/16 grows by one.
  function automatic int carry_of(int k, int fra);
`ifdef UART_BAUDGEN_FRAC_EN
    if (k == 0) return 0;
    return (k * fra) / 16 - ((k - 1) * fra) / 16;
`else
    return 0;
`endif
  endfunction

  // Expected tick value after the current edge, for configuration held constant
  // since the channel was enabled.
  function automatic logic model_step(int ch, bit clr, bit en, int div, int fra);
    if (clr || !en || div == 0) begin
      m_e[ch] = 0;
      m_k[ch] = 0;
      return 1'b0;
    end
    if (m_e[ch] == 0) m_next[ch] = div;
    m_e[ch]++;
    if (m_e[ch] == m_next[ch]) begin
      m_k[ch]++;
      m_next[ch] += div + carry_of(m_k[ch], fra);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock: predict at the rising edge, compare on the falling edge.
  task automatic cycle();
    logic e1, e16;
    @(posedge clk);
    edge_n++;
    e1  = model_step(0, rst, baud_en, int'(divisor), int'(fra_adj));
    e16 = model_step(1, rst, baud_x16_en, int'(divisor_x16), int'(fra_adj_x16));
    @(negedge clk);
    if (o_baud)     q1.push_back(edge_n);
    if (o_baud_x16) q16.push_back(edge_n);
    check($sformatf("o_baud@%0d", edge_n), o_baud, e1);
    check($sformatf("o_baud_x16@%0d", edge_n), o_baud_x16, e16);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Apply a new configuration from a clean phase: drop both enables for one clock.
  task automatic configure(input int d1, input int f1, input bit en1,
                           input int d16, input int f16, input bit en16);
    baud_en = 1'b0;
    baud_x16_en = 1'b0;
    cycle();
    divisor = 16'(d1);
    fra_adj = 4'(f1);
    divisor_x16 = 16'(d16);
    fra_adj_x16 = 4'(f16);
    baud_en = en1;
    baud_x16_en = en16;
  endtask

  initial begin
    int exp_sum;
    logic exp_t;
    // NOTE: stimulus is driven with blocking assignments on the falling edge,
    // away from the edge at which the DUT samples.
    rst = 1'b1;
    divisor = 16'd434;
    fra_adj = 4'd0;
    divisor_x16 = 16'd27;
    fra_adj_x16 = 4'd8;
    baud_en = 1'b0;
    baud_x16_en = 1'b0;
    #1;
    check("reset_o_baud", o_baud, 1'b0);
    check("reset_o_baud_x16", o_baud_x16, 1'b0);
    run(3);

    // Nominal operation: 1x every 434 clocks, 16x at 27 + 8/16 clocks.
    @(negedge clk);
    rst = 1'b0;
    baud_en = 1'b1;
    baud_x16_en = 1'b1;
    q1.delete();
    q16.delete();
    run(2500);
    check_int("first_1x_tick_edge", q1[0] - q1[0] + (q1.size() > 0 ? q1[0] - edge_n + 2500 : -1), 434);
    check_int("1x_interval", q1[1] - q1[0], 434);
`ifdef UART_BAUDGEN_FRAC_EN
    exp_sum = 440;
`else
    exp_sum = 432;
`endif
    check_int("x16_16_intervals_a", q16[16] - q16[0], exp_sum);
    check_int("x16_16_intervals_b", q16[21] - q16[5], exp_sum);

    // Enables drop: outputs low from the next edge, then a clean restart.
    baud_en = 1'b0;
    baud_x16_en = 1'b0;
    run(60);
    baud_en = 1'b1;
    baud_x16_en = 1'b1;
    run(500);

    // Reset mid-interval while o_baud is held high by divisor=1.
    configure(1, 0, 1'b1, 27, 8, 1'b1);
    run(40);
    #7 rst = 1'b1;
    #1;
    check("async_reset_o_baud", o_baud, 1'b0);
    check("async_reset_o_baud_x16", o_baud_x16, 1'b0);
    divisor = 16'd434;
    cycle();
    rst = 1'b0;
    run(500);

    // Divisor 0 idles the channel; divisor 1 with fractions.
    configure(0, 0, 1'b1, 0, 5, 1'b1);
    run(100);
    configure(1, 0, 1'b1, 1, 8, 1'b1);
    run(40);

    // Divisor lowered from 434 to 100 while the count sits at 200.
    configure(434, 0, 1'b1, 0, 0, 1'b0);
    begin
      int base;
      base = edge_n;
      for (int e = 1; e <= 450; e++) begin
        if (e == 201) divisor = 16'd100;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        exp_t = (e == 201) || (e > 201 && (e - 201) % 100 == 0);
        check($sformatf("div_reduce_o_baud@%0d", e), o_baud, exp_t);
        check($sformatf("div_reduce_o_baud_x16@%0d", e), o_baud_x16, 1'b0);
      end
    end
    baud_en = 1'b0;
    cycle();

    // Randomized segments with constant configuration per segment.
    for (int s = 0; s < 20; s++) begin
      int d1, d16;
      d1  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 48));
      d16 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 48));
      configure(d1, int'($urandom_range(0, 15)), $urandom_range(0, 7) != 0,
                d16, int'($urandom_range(0, 15)), $urandom_range(0, 7) != 0);
      run(int'($urandom_range(60, 260)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
